// File: rtl/y86_pkg.sv
// y86_pkg: constants shared by the Y86 pipeline blocks.
//   - icode values that the execute stage decodes here
//   - ifun values that select a branch/cmov condition
//   - bit positions of ZF/SF/OF inside the 3-bit condition-code vector
package y86_pkg;

  localparam logic [3:0] I_CMOVXX = 4'h2;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;

  localparam logic [3:0] C_YES = 4'd0;
  localparam logic [3:0] C_LE  = 4'd1;
  localparam logic [3:0] C_L   = 4'd2;
  localparam logic [3:0] C_E   = 4'd3;
  localparam logic [3:0] C_NE  = 4'd4;
  localparam logic [3:0] C_GE  = 4'd5;
  localparam logic [3:0] C_G   = 4'd6;

  localparam int ZF = 2;
  localparam int SF = 1;
  localparam int OF = 0;

  // True for the instructions whose behaviour depends on a condition.
  function automatic logic is_cond_icode(input logic [3:0] icode);
    return (icode == I_CMOVXX) || (icode == I_JXX);
  endfunction

endpackage

// File: rtl/cond_eval.sv
// cond_eval: purely combinational Y86 condition evaluator.
// Ports:
//   cc   [2:0] in  : condition codes {ZF,SF,OF}
//   ifun [3:0] in  : condition selector
//   cond       out : condition result (0 for undefined selectors)
//   err        out : selector is outside the defined range 0..6
module cond_eval
  import y86_pkg::*;
(
  input  logic [2:0] cc,
  input  logic [3:0] ifun,
  output logic       cond,
  output logic       err
);

  logic zf, sf, of, lt;

  assign zf = cc[ZF];
  assign sf = cc[SF];
  assign of = cc[OF];
  // Signed "less than" after a compare: sign disagrees with overflow.
  assign lt = sf ^ of;

  always_comb begin
    cond = 1'b0;
    err  = 1'b0;
    case (ifun)
      C_YES:   cond = 1'b1;
      C_LE:    cond = lt | zf;
      C_L:     cond = lt;
      C_E:     cond = zf;
      C_NE:    cond = ~zf;
      C_GE:    cond = ~lt;
      C_G:     cond = ~lt & ~zf;
      default: err  = 1'b1;
    endcase
  end

endmodule

// File: rtl/cc_cond_unit.sv
// cc_cond_unit: execute-stage condition-code register and branch/cmov
// condition evaluation for the pipelined Y86 core, with a registered
// result handed to the memory stage.
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   e_valid/e_icode/e_ifun: instruction currently in execute
//   set_cc                : instruction updates the condition codes
//   alu_result/alu_overflow: ALU outputs used to form new codes
//   exc_block             : later-stage exception, blocks CC writes
//   stall, bubble         : pipeline control (stall has priority)
//   cc_out                : current {ZF,SF,OF}
//   m_cnd/m_cnd_valid     : M-stage condition result and its qualifier
//   cond_err              : M-stage flag for an undefined condition code
//   taken_cnt/nottaken_cnt: branch statistics (only with CC_COND_STATS_EN)
// Optional feature macro: CC_COND_STATS_EN.
module cc_cond_unit
  import y86_pkg::*;
#(
  parameter int         WIDTH    = 64,
  parameter logic [2:0] CC_RESET = 3'b100
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             e_valid,
  input  logic [3:0]       e_icode,
  input  logic [3:0]       e_ifun,
  input  logic             set_cc,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_overflow,
  input  logic             exc_block,
  input  logic             stall,
  input  logic             bubble,
  output logic [2:0]       cc_out,
  output logic             m_cnd,
  output logic             m_cnd_valid,
  output logic             cond_err
`ifdef CC_COND_STATS_EN
  ,
  output logic [31:0]      taken_cnt,
  output logic [31:0]      nottaken_cnt
`endif
);

  logic [2:0] cc;
  logic [2:0] cc_next;
  logic       accept;
  logic       cc_we;
  logic       m_load;
  logic       cond;
  logic       err;

  assign accept = e_valid & ~stall;
  // A bubble still lets the instruction's CC update through; it only
  // squashes what is handed to the M stage.
  assign cc_we  = accept & set_cc & ~exc_block;
  assign m_load = accept & ~bubble & is_cond_icode(e_icode);

  always_comb begin
    cc_next     = 3'b000;
    cc_next[ZF] = (alu_result == '0);
    cc_next[SF] = alu_result[WIDTH-1];
    cc_next[OF] = alu_overflow;
  end

  // Evaluated on the stored codes, i.e. the values before this edge.
  cond_eval u_cond_eval (
    .cc   (cc),
    .ifun (e_ifun),
    .cond (cond),
    .err  (err)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cc          <= CC_RESET;
      m_cnd       <= 1'b0;
      m_cnd_valid <= 1'b0;
      cond_err    <= 1'b0;
    end else begin
      if (cc_we) cc <= cc_next;
      if (!stall) begin
        m_cnd       <= m_load & cond;
        m_cnd_valid <= m_load;
        cond_err    <= m_load & err;
      end
    end
  end

  assign cc_out = cc;

`ifdef CC_COND_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      taken_cnt    <= 32'd0;
      nottaken_cnt <= 32'd0;
    end else if (m_load) begin
      if (cond) taken_cnt    <= taken_cnt + 32'd1;
      else      nottaken_cnt <= nottaken_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cc_cond_unit.sv
// tb_cc_cond_unit: directed self-checking bench for cc_cond_unit.
module tb_cc_cond_unit;
  import y86_pkg::*;

  localparam int WIDTH = 64;

  logic             clk = 1'b0;
  logic             reset;
  logic             e_valid;
  logic [3:0]       e_icode;
  logic [3:0]       e_ifun;
  logic             set_cc;
  logic [WIDTH-1:0] alu_result;
  logic             alu_overflow;
  logic             exc_block;
  logic             stall;
  logic             bubble;
  logic [2:0]       cc_out;
  logic             m_cnd;
  logic             m_cnd_valid;
  logic             cond_err;
`ifdef CC_COND_STATS_EN
  logic [31:0]      taken_cnt;
  logic [31:0]      nottaken_cnt;
`endif

  int checks = 0;
  int errors = 0;

  cc_cond_unit #(.WIDTH(WIDTH), .CC_RESET(3'b100)) dut (
    .clk          (clk),
    .reset        (reset),
    .e_valid      (e_valid),
    .e_icode      (e_icode),
    .e_ifun       (e_ifun),
    .set_cc       (set_cc),
    .alu_result   (alu_result),
    .alu_overflow (alu_overflow),
    .exc_block    (exc_block),
    .stall        (stall),
    .bubble       (bubble),
    .cc_out       (cc_out),
    .m_cnd        (m_cnd),
    .m_cnd_valid  (m_cnd_valid),
    .cond_err     (cond_err)
`ifdef CC_COND_STATS_EN
    ,
    .taken_cnt    (taken_cnt),
    .nottaken_cnt (nottaken_cnt)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    e_valid = 1'b0; e_icode = 4'h1; e_ifun = 4'h0; set_cc = 1'b0;
    alu_result = '0; alu_overflow = 1'b0; exc_block = 1'b0;
    stall = 1'b0; bubble = 1'b0;
  endtask

  task automatic drive_jxx(input logic [3:0] icode, input logic [3:0] ifun);
    drive_idle();
    e_valid = 1'b1; e_icode = icode; e_ifun = ifun;
  endtask

  task automatic drive_opq(input logic [WIDTH-1:0] res, input logic ovf);
    drive_idle();
    e_valid = 1'b1; e_icode = I_OPQ; set_cc = 1'b1;
    alu_result = res; alu_overflow = ovf;
  endtask

  // Advance one active edge; outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    drive_idle();
    tick(); tick();
    checks++; if (cc_out !== 3'b100) begin errors++; $display("FAIL reset_cc: got %b exp %b", cc_out, 3'b100); end
    checks++; if (m_cnd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", m_cnd_valid); end
    checks++; if ({m_cnd, cond_err} !== 2'b00) begin errors++; $display("FAIL reset_cnd_err: got %b exp 00", {m_cnd, cond_err}); end
    reset = 1'b0;
    tick();
    checks++; if (cc_out !== 3'b100) begin errors++; $display("FAIL post_reset_cc: got %b exp %b", cc_out, 3'b100); end
    // je on reset codes (ZF=1) -> taken, visible one edge later
    drive_jxx(I_JXX, C_E);
    tick();
    checks++; if ({m_cnd_valid, m_cnd, cond_err} !== 3'b110) begin errors++; $display("FAIL je_after_reset: got %b exp 110", {m_cnd_valid, m_cnd, cond_err}); end
  endtask

  task automatic test_negative();
    drive_opq({WIDTH{1'b1}}, 1'b0);
    tick();
    checks++; if (cc_out !== 3'b010) begin errors++; $display("FAIL neg_cc: got %b exp 010", cc_out); end
    checks++; if (m_cnd_valid !== 1'b0) begin errors++; $display("FAIL opq_valid: got %b exp 0", m_cnd_valid); end
    drive_jxx(I_JXX, C_L);
    tick();
    checks++; if ({m_cnd_valid, m_cnd} !== 2'b11) begin errors++; $display("FAIL neg_jl: got %b exp 11", {m_cnd_valid, m_cnd}); end
    drive_jxx(I_JXX, C_G);
    tick();
    checks++; if ({m_cnd_valid, m_cnd} !== 2'b10) begin errors++; $display("FAIL neg_jg: got %b exp 10", {m_cnd_valid, m_cnd}); end
    // je with set_cc on the same cycle: uses old ZF=0, while cc becomes 100
    drive_jxx(I_JXX, C_E);
    set_cc = 1'b1; alu_result = '0;
    tick();
    checks++; if ({m_cnd_valid, m_cnd} !== 2'b10) begin errors++; $display("FAIL pre_update_je: got %b exp 10", {m_cnd_valid, m_cnd}); end
    checks++; if (cc_out !== 3'b100) begin errors++; $display("FAIL same_cycle_cc: got %b exp 100", cc_out); end
  endtask

  task automatic test_overflow();
    drive_opq({1'b1, {(WIDTH-1){1'b0}}}, 1'b1);
    tick();
    checks++; if (cc_out !== 3'b011) begin errors++; $display("FAIL ovf_cc: got %b exp 011", cc_out); end
    drive_jxx(I_JXX, C_GE);
    tick();
    checks++; if ({m_cnd_valid, m_cnd} !== 2'b11) begin errors++; $display("FAIL ovf_jge: got %b exp 11", {m_cnd_valid, m_cnd}); end
    drive_jxx(I_JXX, C_L);
    tick();
    checks++; if ({m_cnd_valid, m_cnd} !== 2'b10) begin errors++; $display("FAIL ovf_jl: got %b exp 10", {m_cnd_valid, m_cnd}); end
    drive_jxx(I_JXX, C_LE);
    tick();
    checks++; if ({m_cnd_valid, m_cnd} !== 2'b10) begin errors++; $display("FAIL ovf_jle: got %b exp 10", {m_cnd_valid, m_cnd}); end
  endtask

  task automatic test_exc_and_stall();
    drive_opq('0, 1'b0);
    exc_block = 1'b1;
    tick();
    checks++; if (cc_out !== 3'b011) begin errors++; $display("FAIL exc_block_cc: got %b exp 011", cc_out); end
    // load M with a taken jge (cc 011 -> ge true)
    drive_jxx(I_JXX, C_GE);
    tick();
    checks++; if ({m_cnd_valid, m_cnd} !== 2'b11) begin errors++; $display("FAIL stall_preload: got %b exp 11", {m_cnd_valid, m_cnd}); end
    drive_opq('0, 1'b0);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (cc_out !== 3'b011) begin errors++; $display("FAIL stall_cc[%0d]: got %b exp 011", i, cc_out); end
      checks++; if ({m_cnd_valid, m_cnd, cond_err} !== 3'b110) begin errors++; $display("FAIL stall_m[%0d]: got %b exp 110", i, {m_cnd_valid, m_cnd, cond_err}); end
    end
  endtask

  task automatic test_bubble();
    drive_jxx(I_JXX, C_GE);
    bubble = 1'b1;
    tick();
    checks++; if ({m_cnd_valid, m_cnd} !== 2'b00) begin errors++; $display("FAIL bubble_jxx: got %b exp 00", {m_cnd_valid, m_cnd}); end
    // bubble with an OPq: CC still updates (result 0 -> 100)
    drive_opq('0, 1'b0);
    bubble = 1'b1;
    tick();
    checks++; if (cc_out !== 3'b100) begin errors++; $display("FAIL bubble_cc: got %b exp 100", cc_out); end
    drive_jxx(I_CMOVXX, C_E);
    tick();
    checks++; if ({m_cnd_valid, m_cnd} !== 2'b11) begin errors++; $display("FAIL cmove: got %b exp 11", {m_cnd_valid, m_cnd}); end
    drive_jxx(I_JXX, C_NE);
    stall = 1'b1; bubble = 1'b1;
    tick(); tick();
    checks++; if ({m_cnd_valid, m_cnd, cond_err} !== 3'b110) begin errors++; $display("FAIL stall_bubble: got %b exp 110", {m_cnd_valid, m_cnd, cond_err}); end
    drive_jxx(I_CMOVXX, C_NE);
    tick();
    checks++; if ({m_cnd_valid, m_cnd} !== 2'b10) begin errors++; $display("FAIL cmovne: got %b exp 10", {m_cnd_valid, m_cnd}); end
  endtask

  task automatic test_bad_ifun();
    drive_jxx(I_JXX, 4'd9);
    tick();
    checks++; if ({m_cnd_valid, m_cnd, cond_err} !== 3'b101) begin errors++; $display("FAIL ifun9: got %b exp 101", {m_cnd_valid, m_cnd, cond_err}); end
    drive_jxx(I_JXX, 4'd7);
    tick();
    checks++; if ({m_cnd_valid, m_cnd, cond_err} !== 3'b101) begin errors++; $display("FAIL ifun7: got %b exp 101", {m_cnd_valid, m_cnd, cond_err}); end
    // non-conditional icode with a large ifun raises nothing
    drive_jxx(4'h3, 4'd9);
    tick();
    checks++; if ({m_cnd_valid, m_cnd, cond_err} !== 3'b000) begin errors++; $display("FAIL other_icode: got %b exp 000", {m_cnd_valid, m_cnd, cond_err}); end
    drive_jxx(I_JXX, 4'd15);
    tick();
    drive_idle();
    tick();
    checks++; if ({m_cnd_valid, m_cnd, cond_err} !== 3'b000) begin errors++; $display("FAIL invalid_clears: got %b exp 000", {m_cnd_valid, m_cnd, cond_err}); end
  endtask

  task automatic test_async_reset();
    drive_opq({WIDTH{1'b1}}, 1'b1);
    tick();
    drive_jxx(I_JXX, 4'd12);
    tick();
    checks++; if ({cc_out, cond_err} !== 4'b0111) begin errors++; $display("FAIL pre_async: got %b exp 0111", {cc_out, cond_err}); end
    #2 reset = 1'b1;
    #1;
    checks++; if ({cc_out, m_cnd_valid, m_cnd, cond_err} !== 6'b100000) begin errors++; $display("FAIL async_reset: got %b exp 100000", {cc_out, m_cnd_valid, m_cnd, cond_err}); end
    drive_idle();
    tick();
    reset = 1'b0;
  endtask

`ifdef CC_COND_STATS_EN
  task automatic test_stats();
    // cc is 100: jmp taken x3, jne not taken x2
    for (int i = 0; i < 3; i++) begin drive_jxx(I_JXX, C_YES); tick(); end
    for (int i = 0; i < 2; i++) begin drive_jxx(I_JXX, C_NE); tick(); end
    checks++; if (taken_cnt !== 32'd3) begin errors++; $display("FAIL taken_cnt: got %0d exp 3", taken_cnt); end
    checks++; if (nottaken_cnt !== 32'd2) begin errors++; $display("FAIL nottaken_cnt: got %0d exp 2", nottaken_cnt); end
    drive_jxx(I_JXX, C_YES);
    stall = 1'b1;
    tick();
    checks++; if ({taken_cnt, nottaken_cnt} !== {32'd3, 32'd2}) begin errors++; $display("FAIL stats_stall: got %0d/%0d exp 3/2", taken_cnt, nottaken_cnt); end
    drive_jxx(I_JXX, C_YES);
    tick();
    #2 reset = 1'b1;
    #1;
    checks++; if ({taken_cnt, nottaken_cnt} !== 64'd0) begin errors++; $display("FAIL stats_reset: got %0d/%0d exp 0/0", taken_cnt, nottaken_cnt); end
    drive_idle();
    tick();
    reset = 1'b0;
  endtask
`endif

  // ---------------- sequence / report ----------------
  initial begin
    drive_idle();
    test_reset();
    test_negative();
    test_overflow();
    test_exc_and_stall();
    test_bubble();
    test_bad_ifun();
    test_async_reset();
`ifdef CC_COND_STATS_EN
    test_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
